// File: rtl/mult_datapath.sv
// Register and arithmetic datapath for the signed shift-add multiplier.
// It holds X:A:B and applies the Clear/Add/Sub/Shift/Load strobes from the control FSM.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_B,
  input  logic             Clear_XA,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift_En,
  input  logic [WIDTH-1:0] S,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M
);

  logic             arith;
  logic             shift_ok;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;

  // B may only shift when A shifts too, so one qualified shift strobe feeds both registers.
  always_comb begin
    arith    = Add | Sub;
    shift_ok = Shift_En & Load_B & ~arith & ~Clear_XA;
    a_ext    = {Aval[WIDTH-1], Aval};
    s_ext    = {S[WIDTH-1], S};
    sum      = Sub ? (a_ext - s_ext) : (a_ext + s_ext);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      X    <= 1'b0;
      Aval <= '0;
      Bval <= '0;
    end else begin
      if (Clear_XA) begin
        X    <= 1'b0;
        Aval <= '0;
      end else if (arith) begin
        {X, Aval} <= sum;
      end else if (shift_ok) begin
        Aval <= {X, Aval[WIDTH-1:1]};
      end

      if (!Load_B) begin
        Bval <= S;
      end else if (shift_ok) begin
        Bval <= {Aval[0], Bval[WIDTH-1:1]};
      end
    end
  end

  assign M = Bval[0];

endmodule
